// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with memory freeze, branch flush, load-use stall and forwarding.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic [7:0] id_ctrl,
  input  logic       ex_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic [7:0] idex_ctrl,
  output logic [7:0] exmem_ctrl,
  output logic       memwb_regwrite,
  output logic       memwb_memtoreg,
  output logic [4:0] idex_rd,
  output logic [4:0] exmem_rd,
  output logic [4:0] memwb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state,
  output logic [15:0] bubble_cnt
);
  localparam int BR = 5, MR = 4, MTR = 3, MW = 2, RW = 0;
  typedef enum logic [1:0] {RUN, LOADUSE, FLUSH, MEMWAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] idex_ctrl_q, idex_ctrl_d, exmem_ctrl_q, exmem_ctrl_d;
  logic [4:0] idex_rd_q, idex_rd_d, idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
  logic [4:0] exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
  logic memwb_regwrite_q, memwb_regwrite_d, memwb_memtoreg_q, memwb_memtoreg_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic freeze, flush, load_use, bubble;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic ex_rw,
                                         input logic [4:0] ex_rd, input logic wb_rw,
                                         input logic [4:0] wb_rd);
    return (ex_rw && ex_rd != 5'd0 && ex_rd == rs) ? 2'b10 :
           (wb_rw && wb_rd != 5'd0 && wb_rd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    freeze   = (exmem_ctrl_q[MR] | exmem_ctrl_q[MW]) & ~mem_ready;
    flush    = ~freeze & idex_ctrl_q[BR] & ex_taken;
    load_use = ~freeze & ~flush & idex_ctrl_q[MR] & (idex_rd_q != 5'd0) & id_valid &
               (idex_rd_q == id_rs1 || idex_rd_q == id_rs2);
    bubble   = flush | load_use;
    idex_ctrl_d      = idex_ctrl_q;
    idex_rd_d        = idex_rd_q;
    idex_rs1_d       = idex_rs1_q;
    idex_rs2_d       = idex_rs2_q;
    exmem_ctrl_d     = exmem_ctrl_q;
    exmem_rd_d       = exmem_rd_q;
    memwb_regwrite_d = memwb_regwrite_q;
    memwb_memtoreg_d = memwb_memtoreg_q;
    memwb_rd_d       = memwb_rd_q;
    if (!freeze) begin
      idex_ctrl_d      = (bubble || !id_valid) ? 8'd0 : id_ctrl;
      idex_rd_d        = bubble ? 5'd0 : id_rd;
      idex_rs1_d       = bubble ? 5'd0 : id_rs1;
      idex_rs2_d       = bubble ? 5'd0 : id_rs2;
      exmem_ctrl_d     = idex_ctrl_q;
      exmem_rd_d       = idex_rd_q;
      memwb_regwrite_d = exmem_ctrl_q[RW];
      memwb_memtoreg_d = exmem_ctrl_q[MTR];
      memwb_rd_d       = exmem_rd_q;
    end
    state_d      = freeze ? MEMWAIT : flush ? FLUSH : load_use ? LOADUSE : RUN;
    bubble_cnt_d = (bubble && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      idex_ctrl_q      <= '0;
      idex_rd_q        <= '0;
      idex_rs1_q       <= '0;
      idex_rs2_q       <= '0;
      exmem_ctrl_q     <= '0;
      exmem_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_rd_q       <= '0;
      bubble_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      idex_ctrl_q      <= idex_ctrl_d;
      idex_rd_q        <= idex_rd_d;
      idex_rs1_q       <= idex_rs1_d;
      idex_rs2_q       <= idex_rs2_d;
      exmem_ctrl_q     <= exmem_ctrl_d;
      exmem_rd_q       <= exmem_rd_d;
      memwb_regwrite_q <= memwb_regwrite_d;
      memwb_memtoreg_q <= memwb_memtoreg_d;
      memwb_rd_q       <= memwb_rd_d;
      bubble_cnt_q     <= bubble_cnt_d;
    end
  end
  // Enables are gated by rst_n so reset takes effect without waiting for a clock.
  assign pc_write       = rst_n & ~freeze & ~load_use;
  assign ifid_write     = rst_n & ~freeze & ~load_use;
  assign ifid_flush     = ~rst_n | flush;
  assign idex_ctrl      = idex_ctrl_q;
  assign exmem_ctrl     = exmem_ctrl_q;
  assign memwb_regwrite = memwb_regwrite_q;
  assign memwb_memtoreg = memwb_memtoreg_q;
  assign idex_rd        = idex_rd_q;
  assign exmem_rd       = exmem_rd_q;
  assign memwb_rd       = memwb_rd_q;
  assign fwd_a          = fwd_sel(idex_rs1_q, exmem_ctrl_q[RW], exmem_rd_q, memwb_regwrite_q, memwb_rd_q);
  assign fwd_b          = fwd_sel(idex_rs2_q, exmem_ctrl_q[RW], exmem_rd_q, memwb_regwrite_q, memwb_rd_q);
  assign state          = state_q;
  assign bubble_cnt     = bubble_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1 bit: decode stage holds a real instruction.
REQ-004 SHALL have ports id_rs1, id_rs2, id_rd, input, 5 bits each: decode-stage register indices.
REQ-005 SHALL have port id_ctrl, input, 8 bits: decoder output packed {ALUop[1:0], branch, memRead, memtoReg, memWrite, ALUsrc, regWrite}.
REQ-006 SHALL have port ex_taken, input, 1 bit: EX-stage branch comparison true.
REQ-007 SHALL have port mem_ready, input, 1 bit: data memory completes the current access this cycle.
REQ-008 SHALL have ports pc_write and ifid_write, output, 1 bit each: PC and IF/ID enables.
REQ-009 SHALL have port ifid_flush, output, 1 bit: zero the IF/ID instruction.
REQ-010 SHALL have ports idex_ctrl and exmem_ctrl, output, 8 bits each, plus memwb_regwrite and memwb_memtoreg, output, 1 bit each: staged control.
REQ-011 SHALL have ports idex_rd, exmem_rd, memwb_rd, output, 5 bits each: staged destinations.
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2 bits each: EX operand select (00 regfile, 01 MEM/WB, 10 EX/MEM).
REQ-013 SHALL have port state, output, 2 bits: registered cause of the previous cycle (00 RUN, 01 LOADUSE, 10 FLUSH, 11 MEMWAIT).
REQ-014 SHALL have port bubble_cnt, output, 16 bits: saturating count of inserted bubbles.

Function
REQ-015 SHALL hold internal idex_rs1/idex_rs2 registers captured with idex_ctrl.
REQ-016 SHALL detect freeze: exmem_ctrl memRead or memWrite is 1 and mem_ready is 0.
REQ-017 On freeze, all pipeline registers SHALL hold, pc_write=0, ifid_write=0, ifid_flush=0, ex_taken ignored, next state=MEMWAIT.
REQ-018 SHALL detect flush when not frozen: idex_ctrl branch=1 and ex_taken=1.
REQ-019 On flush, ifid_flush=1, pc_write=1, ID/EX loads zero (bubble), next state=FLUSH.
REQ-020 SHALL detect load-use when not frozen and not flushing: idex_ctrl memRead=1, idex_rd!=0, id_valid=1, idex_rd equal to id_rs1 or id_rs2.
REQ-021 On load-use, pc_write=0, ifid_write=0, ID/EX loads zero, next state=LOADUSE; load-use SHALL never fire two consecutive cycles.
REQ-022 Priority SHALL be freeze > flush > load-use > run.
REQ-023 In run, pc_write=1, ifid_write=1, ID/EX loads id_ctrl (zero if id_valid=0) and id_rd/rs1/rs2; next state=RUN.
REQ-024 When not frozen, EX/MEM SHALL load ID/EX and MEM/WB SHALL load EX/MEM each cycle.
REQ-025 fwd_a SHALL be 10 if exmem regWrite=1, exmem_rd!=0, exmem_rd==idex_rs1; else 01 if memwb_regwrite=1, memwb_rd!=0, memwb_rd==idex_rs1; else 00; fwd_b identical using idex_rs2.
REQ-026 Forwarding SHALL be combinational from registered state, valid during freeze.
REQ-027 bubble_cnt SHALL increment by 1 on each flush or load-use cycle and saturate at 0xFFFF.

Reset
REQ-028 While rst_n=0, all control/rd registers, idex_rs1/rs2, bubble_cnt SHALL be 0, state=RUN, pc_write=0, ifid_write=0, ifid_flush=1.
REQ-029 Reset assertion mid-freeze or mid-stall SHALL abort immediately; first cycle after release SHALL be RUN with an empty pipeline.

Verification
REQ-030 lw x5 in ID/EX (memRead, rd=5), ID has rs1=5 -> pc_write=0, ifid_write=0, next idex_ctrl=0x00, state=01, bubble_cnt+1.
REQ-031 Branch in ID/EX, ex_taken=1 -> ifid_flush=1, next idex_ctrl=0x00, state=10; ex_taken=1 with branch=0 -> no effect.
REQ-032 exmem memRead=1, mem_ready=0 for 3 cycles -> all staged outputs constant, pc_write=0, state=11; mem_ready=1 -> pipeline advances once.
REQ-033 exmem regWrite rd=3 and memwb regWrite rd=3, idex_rs1=3 -> fwd_a=10; rd=0 in both -> fwd_a=00.
REQ-034 Load-use and taken branch same cycle -> flush only, state=10; bubble_cnt preset 0xFFFF -> stays 0xFFFF.
REQ-035 rst_n low during MEMWAIT -> outputs per REQ-028 asynchronously, state=00.
